rfid_wb_arbiter: RTL and testbench

Wishbone bus master and two-port arbiter that drives the shared peripheral bus of the RFID top level. The bus carries cyc, per-slave stb[1:0], adr[2:0], we and an 8-bit data bus. Slave 0 is the SPI controller, which decodes only adr[1:0]; slave 1 is the I2C master, which decodes adr[2:0]. The block accepts single-byte register read/write commands from two requesters (req0 = tag protocol engine, req1 = debug/host port), grants them round-robin, runs one classic Wishbone cycle per command, and returns the read data or a timeout error.

---
 rtl/rfid_bus_pkg.sv | 12 +
 rtl/rfid_rr_arb2.sv | 17 +
 rtl/rfid_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_rfid_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfid_bus_pkg.sv
// rfid_bus_pkg: shared state encoding, slave ids, bus widths and address legality for the RFID peripheral bus
package rfid_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_e;
  localparam logic SLV_SPI = 1'b0;
  localparam logic SLV_I2C = 1'b1;
  localparam int WB_ADR_W = 3;
  localparam int WB_DAT_W = 8;
  localparam int SPI_ADR_MAX = 3;
  function automatic logic adr_illegal(input logic sel, input logic [WB_ADR_W-1:0] a);
    return sel == SLV_SPI && a > WB_ADR_W'(SPI_ADR_MAX);
  endfunction
endpackage

// File: rtl/rfid_rr_arb2.sv
// rfid_rr_arb2: two-request round-robin arbiter holding the last-granted index
module rfid_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  always_comb begin
    gnt = !en ? 2'b00 : (&req) ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = |gnt ? gnt[1] : last_q;
  end
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/rfid_wb_arbiter.sv
// rfid_wb_arbiter: Wishbone master running one register cycle per command from two round-robin requesters
module rfid_wb_arbiter
  import rfid_bus_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic                req0_sel,
  input  logic                req0_we,
  input  logic [WB_ADR_W-1:0] req0_adr,
  input  logic [WB_DAT_W-1:0] req0_wdat,
  output logic                req0_done,
  output logic                req0_err,
  output logic [WB_DAT_W-1:0] req0_rdat,
  input  logic                req1_valid,
  input  logic                req1_sel,
  input  logic                req1_we,
  input  logic [WB_ADR_W-1:0] req1_adr,
  input  logic [WB_DAT_W-1:0] req1_wdat,
  output logic                req1_done,
  output logic                req1_err,
  output logic [WB_DAT_W-1:0] req1_rdat,
  output logic                cyc,
  output logic [1:0]          stb,
  output logic [WB_ADR_W-1:0] adr,
  output logic                we,
  output logic [WB_DAT_W-1:0] dat,
  input  logic [WB_DAT_W-1:0] dat_i_spi,
  input  logic                ack_spi,
  input  logic [WB_DAT_W-1:0] dat_i_i2c,
  input  logic                ack_i2c
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic g_q, g_d;
  logic cyc_q, cyc_d;
  logic [1:0] stb_q, stb_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic we_q, we_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [1:0] done_q, done_d, err_q, err_d;
  logic [WB_DAT_W-1:0] rdat_q [2];
  logic [WB_DAT_W-1:0] rdat_d [2];
  logic [1:0] gnt;
  logic gsel, gwe, ack, fin, ferr;
  logic [WB_ADR_W-1:0] gadr;
  logic [WB_DAT_W-1:0] gwdat, din, frd;
  rfid_rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .en (state_q == ST_IDLE),
    .req({req1_valid, req0_valid}),
    .gnt(gnt)
  );
  always_comb begin
    gsel = gnt[1] ? req1_sel : req0_sel;
    gwe = gnt[1] ? req1_we : req0_we;
    gadr = gnt[1] ? req1_adr : req0_adr;
    gwdat = gnt[1] ? req1_wdat : req0_wdat;
    ack = stb_q[SLV_I2C] ? ack_i2c : ack_spi;
    din = stb_q[SLV_I2C] ? dat_i_i2c : dat_i_spi;
    state_d = state_q;
    cnt_d = cnt_q;
    g_d = g_q;
    cyc_d = cyc_q;
    stb_d = stb_q;
    adr_d = adr_q;
    we_d = we_q;
    dat_d = dat_q;
    fin = 1'b0;
    ferr = 1'b0;
    frd = '0;
    case (state_q)
      ST_IDLE: if (|gnt) begin
        g_d = gnt[1];
        adr_d = gadr;
        we_d = gwe;
        dat_d = gwdat;
        if (adr_illegal(gsel, gadr)) begin
          state_d = ST_RESP;
          fin = 1'b1;
          ferr = 1'b1;
        end else begin
          state_d = ST_BUS;
          cyc_d = 1'b1;
          stb_d = gsel ? 2'b10 : 2'b01;
        end
      end
      ST_BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          cyc_d = 1'b0;
          stb_d = 2'b00;
          fin = 1'b1;
          ferr = !ack;
          frd = ack ? din : '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d = '0;
      end
    endcase
    done_d = fin ? (g_d ? 2'b10 : 2'b01) : 2'b00;
    err_d = ferr ? done_d : 2'b00;
    rdat_d[0] = done_d[0] ? frd : rdat_q[0];
    rdat_d[1] = done_d[1] ? frd : rdat_q[1];
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      g_q <= 1'b0;
      cyc_q <= 1'b0;
      stb_q <= 2'b00;
      adr_q <= '0;
      we_q <= 1'b0;
      dat_q <= '0;
      done_q <= 2'b00;
      err_q <= 2'b00;
      rdat_q[0] <= '0;
      rdat_q[1] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      g_q <= g_d;
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      adr_q <= adr_d;
      we_q <= we_d;
      dat_q <= dat_d;
      done_q <= done_d;
      err_q <= err_d;
      rdat_q[0] <= rdat_d[0];
      rdat_q[1] <= rdat_d[1];
    end
  assign cyc = cyc_q;
  assign stb = stb_q;
  assign adr = adr_q;
  assign we = we_q;
  assign dat = dat_q;
  assign req0_done = done_q[0];
  assign req1_done = done_q[1];
  assign req0_err = err_q[0];
  assign req1_err = err_q[1];
  assign req0_rdat = rdat_q[0];
  assign req1_rdat = rdat_q[1];
endmodule

// File: tb/tb_rfid_wb_arbiter.sv
// tb_rfid_wb_arbiter: randomized self-checking bench for the Wishbone arbiter against a transaction-level model
module tb_rfid_wb_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 0, req0_sel = 0, req0_we = 0;
  logic [2:0] req0_adr = 0;
  logic [7:0] req0_wdat = 0;
  logic req1_valid = 0, req1_sel = 0, req1_we = 0;
  logic [2:0] req1_adr = 0;
  logic [7:0] req1_wdat = 0;
  logic req0_done, req0_err, req1_done, req1_err, cyc, we;
  logic [7:0] req0_rdat, req1_rdat, dat;
  logic [1:0] stb;
  logic [2:0] adr;
  logic [7:0] dat_i_spi = 0, dat_i_i2c = 0;
  logic ack_spi = 0, ack_i2c = 0;
  int checks = 0, errors = 0;
  int ack_dly = 0, k = 0;
  logic spur = 0;
  logic lg = 1'b1;
  logic [7:0] m_rd [2];
  always #5 clk = ~clk;
  rfid_wb_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_we(req0_we), .req0_adr(req0_adr),
    .req0_wdat(req0_wdat), .req0_done(req0_done), .req0_err(req0_err), .req0_rdat(req0_rdat),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_we(req1_we), .req1_adr(req1_adr),
    .req1_wdat(req1_wdat), .req1_done(req1_done), .req1_err(req1_err), .req1_rdat(req1_rdat),
    .cyc(cyc), .stb(stb), .adr(adr), .we(we), .dat(dat),
    .dat_i_spi(dat_i_spi), .ack_spi(ack_spi), .dat_i_i2c(dat_i_i2c), .ack_i2c(ack_i2c)
  );
  always @(negedge clk) begin
    if (rst || cyc !== 1'b1) begin
      k <= 0;
      ack_spi <= 1'b0;
      ack_i2c <= 1'b0;
    end else begin
      k <= k + 1;
      ack_spi <= stb[0] ? (k == ack_dly) : spur;
      ack_i2c <= stb[1] ? (k == ack_dly) : spur;
    end
  end
  task automatic drive(input logic p, input logic v, input logic s, input logic w,
                       input logic [2:0] a, input logic [7:0] d);
    if (p) begin
      req1_valid = v; req1_sel = s; req1_we = w; req1_adr = a; req1_wdat = d;
    end else begin
      req0_valid = v; req0_sel = s; req0_we = w; req0_adr = a; req0_wdat = d;
    end
  endtask
  task automatic do_cmd(input string nm, input logic p, input logic s, input logic w,
                        input logic [2:0] a, input logic [7:0] wd, input int dly,
                        input logic [7:0] rd, input logic sp);
    logic ill, exp_err, seen, got_err;
    logic [7:0] exp_rd;
    int exp_n, nb, dc;
    ill = !s && a[2];
    exp_n = ill ? 0 : (dly + 1 < TO ? dly + 1 : TO);
    exp_err = ill || dly >= TO;
    exp_rd = exp_err ? 8'h00 : rd;
    @(negedge clk);
    ack_dly = dly;
    spur = sp;
    dat_i_spi = s ? ~rd : rd;
    dat_i_i2c = s ? rd : ~rd;
    drive(p, 1'b1, s, w, a, wd);
    nb = 0;
    dc = -1;
    seen = 1'b0;
    for (int c = 0; c < TO + 8 && !seen; c++) begin
      @(negedge clk);
      checks++;
      if (stb === 2'b11 || (stb !== 2'b00 && cyc !== 1'b1)) begin
        errors++;
        $display("FAIL %s invariant: cyc=%b stb=%b", nm, cyc, stb);
      end
      if (cyc === 1'b1) begin
        nb++;
        checks++;
        if ({stb, adr, we, dat} !== {(s ? 2'b10 : 2'b01), a, w, wd}) begin
          errors++;
          $display("FAIL %s bus: stb=%b adr=%0d we=%b dat=%h expected stb=%b adr=%0d we=%b dat=%h",
                   nm, stb, adr, we, dat, (s ? 2'b10 : 2'b01), a, w, wd);
        end
      end
      if (req0_done === 1'b1 || req1_done === 1'b1) begin
        seen = 1'b1;
        dc = c;
      end
    end
    m_rd[p] = exp_rd;
    lg = p;
    got_err = p ? req1_err : req0_err;
    checks++;
    if (dc != exp_n) begin
      errors++;
      $display("FAIL %s latency: done at %0d expected %0d", nm, dc, exp_n);
    end
    checks++;
    if (nb != exp_n) begin
      errors++;
      $display("FAIL %s bus_cycles: got %0d expected %0d", nm, nb, exp_n);
    end
    checks++;
    if ({req1_done, req0_done} !== (p ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL %s done_port: got %b expected %b", nm, {req1_done, req0_done}, (p ? 2'b10 : 2'b01));
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", nm, got_err, exp_err);
    end
    checks++;
    if (req0_rdat !== m_rd[0] || req1_rdat !== m_rd[1]) begin
      errors++;
      $display("FAIL %s rdat: got %h/%h expected %h/%h", nm, req0_rdat, req1_rdat, m_rd[0], m_rd[1]);
    end
    drive(p, 1'b0, s, w, a, wd);
    @(negedge clk);
    checks++;
    if ({req1_done, req0_done, cyc} !== 3'b000) begin
      errors++;
      $display("FAIL %s pulse_gap: done=%b%b cyc=%b expected 000", nm, req1_done, req0_done, cyc);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_rd[0] = 8'h00;
    m_rd[1] = 8'h00;
    lg = 1'b1;
    checks++;
    if ({cyc, stb, adr, we, dat, req0_done, req1_done, req0_err, req1_err, req0_rdat, req1_rdat} !== '0) begin
      errors++;
      $display("FAIL reset: cyc=%b stb=%b adr=%0d we=%b dat=%h done=%b%b err=%b%b rdat=%h/%h expected all zero",
               cyc, stb, adr, we, dat, req1_done, req0_done, req1_err, req0_err, req0_rdat, req1_rdat);
    end
  endtask
  task automatic test_spi_write;
    do_cmd("spi_write", 1'b0, 1'b0, 1'b1, 3'd2, 8'hA5, 0, 8'h5E, 1'b0);
  endtask
  task automatic test_i2c_read;
    do_cmd("i2c_read", 1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 1, 8'h3C, 1'b1);
  endtask
  task automatic test_timeout;
    do_cmd("timeout", 1'b1, 1'b1, 1'b0, 3'd6, 8'h12, 99, 8'h77, 1'b0);
    do_cmd("ack_last", 1'b0, 1'b1, 1'b0, 3'd1, 8'h34, TO - 1, 8'h9A, 1'b1);
  endtask
  task automatic test_illegal;
    do_cmd("illegal", 1'b0, 1'b0, 1'b1, 3'd5, 8'hC3, 0, 8'h44, 1'b0);
  endtask
  task automatic test_random;
    for (int i = 0; i < 24; i++)
      do_cmd("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 5), 8'($urandom),
             1'($urandom_range(0, 1)));
  endtask
  task automatic test_contention(input int n);
    logic cs [2];
    logic cw [2];
    logic [2:0] ca [2];
    logic [7:0] cd [2];
    logic ep, prev_cyc, got_err;
    logic [1:0] prev_stb;
    logic [7:0] exp_rd;
    int got, rdrv;
    for (int i = 0; i < 2; i++) begin
      cs[i] = 1'($urandom_range(0, 1));
      ca[i] = cs[i] ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      cw[i] = 1'($urandom_range(0, 1));
      cd[i] = 8'($urandom);
    end
    @(negedge clk);
    spur = 1'b0;
    ack_dly = $urandom_range(0, 2);
    dat_i_spi = 8'($urandom);
    dat_i_i2c = 8'($urandom);
    drive(1'b0, 1'b1, cs[0], cw[0], ca[0], cd[0]);
    drive(1'b1, 1'b1, cs[1], cw[1], ca[1], cd[1]);
    got = 0;
    rdrv = -1;
    prev_cyc = 1'b0;
    prev_stb = 2'b00;
    for (int c = 0; c < n * 12 && got < n; c++) begin
      @(negedge clk);
      if (rdrv >= 0) begin
        drive(1'(rdrv), 1'b1, cs[rdrv], cw[rdrv], ca[rdrv], cd[rdrv]);
        rdrv = -1;
      end
      checks++;
      if (stb === 2'b11 || (stb !== 2'b00 && cyc !== 1'b1) || (cyc === 1'b1 && prev_cyc && stb !== prev_stb)) begin
        errors++;
        $display("FAIL contention invariant: cyc=%b stb=%b prev_cyc=%b prev_stb=%b", cyc, stb, prev_cyc, prev_stb);
      end
      if (req0_done === 1'b1 || req1_done === 1'b1) begin
        ep = !lg;
        exp_rd = cs[ep] ? dat_i_i2c : dat_i_spi;
        m_rd[ep] = exp_rd;
        got_err = req0_err | req1_err;
        checks++;
        if ({req1_done, req0_done} !== (ep ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL contention grant %0d: done=%b expected %b", got, {req1_done, req0_done}, (ep ? 2'b10 : 2'b01));
        end
        checks++;
        if (got_err !== 1'b0 || req0_rdat !== m_rd[0] || req1_rdat !== m_rd[1]) begin
          errors++;
          $display("FAIL contention data %0d: err=%b rdat=%h/%h expected err=0 rdat=%h/%h",
                   got, got_err, req0_rdat, req1_rdat, m_rd[0], m_rd[1]);
        end
        lg = ep;
        drive(ep, 1'b0, cs[ep], cw[ep], ca[ep], cd[ep]);
        cs[ep] = 1'($urandom_range(0, 1));
        ca[ep] = cs[ep] ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
        cw[ep] = 1'($urandom_range(0, 1));
        cd[ep] = 8'($urandom);
        ack_dly = $urandom_range(0, 2);
        dat_i_spi = 8'($urandom);
        dat_i_i2c = 8'($urandom);
        rdrv = int'(ep);
        got++;
      end
      prev_cyc = (cyc === 1'b1);
      prev_stb = stb;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL contention count: got %0d dones expected %0d", got, n);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset_mid_bus;
    logic found;
    @(negedge clk);
    ack_dly = 99;
    spur = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h66);
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      found = (stb === 2'b01);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_bus start: stb=%b expected 01", stb);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h66);
    @(negedge clk);
    rst = 1'b0;
    m_rd[0] = 8'h00;
    m_rd[1] = 8'h00;
    lg = 1'b1;
    checks++;
    if ({cyc, stb, req0_done, req1_done, req0_rdat, req1_rdat} !== '0) begin
      errors++;
      $display("FAIL reset_mid_bus: cyc=%b stb=%b done=%b%b rdat=%h/%h expected zero",
               cyc, stb, req1_done, req0_done, req0_rdat, req1_rdat);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({cyc, req0_done, req1_done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_bus quiet: cyc=%b done=%b%b expected 000", cyc, req1_done, req0_done);
      end
    end
    test_contention(2);
  endtask
  initial begin
    test_reset();
    test_spi_write();
    test_i2c_read();
    test_timeout();
    test_illegal();
    test_random();
    test_contention(8);
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
